// File: rtl/pwm_pkg.sv
// Shared definitions for the count-driven PWM block.
// State encodings are fixed so that legacy software and the debug dumps stay readable.
// No logic lives here.
package pwm_pkg;

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t ST_IDLE  = 2'd0;
    localparam pwm_state_t ST_ARM   = 2'd1;
    localparam pwm_state_t ST_RUN   = 2'd2;
    localparam pwm_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/count_wrap_detect.sv
// Classifies each sample of the upstream mod-n count: boundary, resync jump, out-of-range.
// Latency: combinational on cnt_in, using a one-sample history register.
// Backpressure: none; a new sample is examined every clk.
module count_wrap_detect #(
    parameter int n = 8,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cnt_in,
    output logic         boundary,
    output logic         resync,
    output logic         range_err
);
    localparam logic [N-1:0] CNT_LAST = N'(n - 1);
    localparam logic [N:0]   CNT_MOD  = (N + 1)'(n);

    logic [N-1:0] prev;
    logic         wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= cnt_in;
        end
    end

    assign boundary  = (cnt_in == '0);
    assign wrap      = boundary && (prev == CNT_LAST);
    // A zero reached from the reset value of prev is a normal start, not a jump.
    assign resync    = boundary && (prev != '0) && !wrap;
    assign range_err = ({1'b0, cnt_in} >= CNT_MOD);

endmodule

// File: rtl/pwm_from_count.sv
// PWM generator slaved to an external mod-n up-counter, duty updated only on period boundaries.
// Latency: pwm_out and period_tick are registered, one clk after the cnt_in sample.
// Backpressure: duty_ready drops while a shadow duty is pending until the next boundary.
module pwm_from_count
    import pwm_pkg::*;
#(
    parameter int n = 8,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cnt_in,
    input  logic         start,
    input  logic         stop,
    input  logic [N:0]   duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         pwm_out,
    output logic         period_tick,
    output logic         busy,
    output logic         cnt_err
);
    localparam logic [N:0] DUTY_MAX = (N + 1)'(n);

    pwm_state_t state, state_nxt;
    logic [N:0] duty_active, shadow, duty_sat, duty_eff;
    logic       pending, xfer;
    logic       boundary, resync, range_err;
    logic       hit, pwm_nxt, tick_nxt;

    count_wrap_detect #(
        .n(n),
        .N(N)
    ) u_detect (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .boundary (boundary),
        .resync   (resync),
        .range_err(range_err)
    );

    assign duty_ready = !pending;
    assign xfer       = duty_valid && !pending;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        duty_sat = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
        // A pending duty takes effect in the very boundary cycle that applies it.
        duty_eff = (boundary && pending) ? shadow : duty_active;
        hit      = !range_err && ({1'b0, cnt_in} < duty_eff);
    end

    always_comb begin
        state_nxt = state;
        pwm_nxt   = 1'b0;
        tick_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (boundary) begin
                    state_nxt = ST_RUN;
                    pwm_nxt   = hit;
                end
            end
            ST_RUN: begin
                pwm_nxt  = hit;
                tick_nxt = boundary;
                if (stop) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                tick_nxt = boundary;
                if (start) begin
                    state_nxt = ST_RUN;
                    pwm_nxt   = hit;
                end else if (boundary) begin
                    state_nxt = ST_IDLE;
                end else begin
                    pwm_nxt = hit;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
            cnt_err     <= 1'b0;
            duty_active <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pwm_out     <= pwm_nxt;
            period_tick <= tick_nxt;
            if (range_err || resync) cnt_err <= 1'b1;
            // Apply and accept are exclusive: duty_ready is low whenever pending is set.
            if (boundary && pending) begin
                duty_active <= shadow;
                pending     <= 1'b0;
            end else if (xfer) begin
                shadow  <= duty_sat;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_from_count.sv
// Randomised scoreboard bench for pwm_from_count driven by a free-running mod-8 counter,
// plus a short directed check of an n=9, N=4 build for out-of-range counts.
module tb_pwm_from_count;
    localparam int n = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst, start, stop, duty_valid;
    logic [N-1:0] cnt_in;
    logic [N:0]   duty_in;
    logic         duty_ready, pwm_out, period_tick, busy, cnt_err;

    logic       rst2, start2, stop2, dv2;
    logic [3:0] cnt2;
    logic [4:0] di2;
    logic       dr2, pwm2, tick2, busy2, err2;

    always #5 clk = ~clk;

    pwm_from_count #(.n(n), .N(N)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .start(start), .stop(stop),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm_out(pwm_out), .period_tick(period_tick), .busy(busy), .cnt_err(cnt_err)
    );

    pwm_from_count #(.n(9), .N(4)) dut9 (
        .clk(clk), .rst(rst2), .cnt_in(cnt2), .start(start2), .stop(stop2),
        .duty_in(di2), .duty_valid(dv2), .duty_ready(dr2),
        .pwm_out(pwm2), .period_tick(tick2), .busy(busy2), .cnt_err(err2)
    );

    typedef struct packed {
        logic pwm;
        logic tick;
        logic busy;
        logic err;
        logic rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   up     = 0;

    // Reference model: activity flags, duty registers and count history.
    bit m_arm, m_run, m_drain, m_pend, m_err;
    int m_duty, m_shadow, m_prev;

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        exp_t e;
        int   c   = int'(cnt_in);
        bit   bnd = (c == 0);
        bit   oor = (c >= n);
        int   eff;
        bit   hit, take;
        e = '0;
        if (rst) begin
            {m_arm, m_run, m_drain, m_pend, m_err} = '0;
            m_duty = 0; m_shadow = 0; m_prev = 0;
            e.rdy = 1'b1;
            exp_q.push_back(e);
            return;
        end
        if (oor || (bnd && m_prev != 0 && m_prev != n - 1)) m_err = 1'b1;
        eff  = (bnd && m_pend) ? m_shadow : m_duty;
        hit  = !oor && (c < eff);
        take = duty_valid && !m_pend;
        if (bnd && m_pend) begin
            m_duty = m_shadow;
            m_pend = 1'b0;
        end else if (take) begin
            m_shadow = (int'(duty_in) > n) ? n : int'(duty_in);
            m_pend   = 1'b1;
        end
        if (m_arm) begin
            if (stop) m_arm = 1'b0;
            else if (bnd) begin m_arm = 1'b0; m_run = 1'b1; e.pwm = hit; end
        end else if (m_run) begin
            e.pwm  = hit;
            e.tick = bnd;
            if (stop) begin m_run = 1'b0; m_drain = 1'b1; end
        end else if (m_drain) begin
            e.tick = bnd;
            if (start) begin m_drain = 1'b0; m_run = 1'b1; e.pwm = hit; end
            else if (bnd) m_drain = 1'b0;
            else e.pwm = hit;
        end else if (start) begin
            m_arm = 1'b1;
        end
        e.busy = m_arm | m_run | m_drain;
        e.err  = m_err;
        e.rdy  = !m_pend;
        m_prev = c;
        exp_q.push_back(e);
    endfunction

    // Drive one sample of the upstream counter, predict, then advance at the next negedge.
    task automatic cycle();
        cnt_in = N'(up);
        model_step();
        @(negedge clk);
        up = (int'(cnt_in) + 1) % n;
        start = 1'b0; stop = 1'b0; duty_valid = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic wait_up(input int v);
        for (int i = 0; i < 2 * n && up != v; i++) cycle();
    endtask

    task automatic send_duty(input int d);
        wait_up(2);
        duty_in = (N + 1)'(d);
        duty_valid = 1'b1;
        cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pwm_out",     pwm_out,     e.pwm);
                cmp("period_tick", period_tick, e.tick);
                cmp("busy",        busy,        e.busy);
                cmp("cnt_err",     cnt_err,     e.err);
                cmp("duty_ready",  duty_ready,  e.rdy);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; stop = 1'b0; duty_valid = 1'b0; duty_in = '0; cnt_in = '0;
        rst2 = 1'b1; start2 = 1'b0; stop2 = 1'b0; dv2 = 1'b0; di2 = '0; cnt2 = '0;
        @(negedge clk);
        run(3);
        rst = 1'b0;

        send_duty(3);
        wait_up(3); start = 1'b1; cycle();
        run(32);

        wait_up(4); duty_in = 4'd6; duty_valid = 1'b1; cycle();
        run(24);

        send_duty(0);  run(20);
        send_duty(8);  run(20);
        send_duty(15); run(20);
        send_duty(3);  run(10);

        wait_up(2); stop = 1'b1;  cycle();
        wait_up(5); start = 1'b1; cycle();
        run(10);
        wait_up(2); stop = 1'b1;  cycle();
        run(12);

        start = 1'b1; cycle();
        run(12);
        wait_up(5); up = 0; cycle();
        run(12);

        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 149) == 0);
            start      = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 19) == 0);
            duty_valid = ($urandom_range(0, 3) == 0);
            duty_in    = (N + 1)'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) up = $urandom_range(0, n - 1);
            cycle();
        end
        rst = 1'b0;

        send_duty(5);
        start = 1'b1; cycle();
        run(12);
        wait_up(3); duty_in = 4'd2; duty_valid = 1'b1; cycle();
        rst = 1'b1; cycle();
        rst = 1'b0;
        run(4);

        // Wider build: an out-of-range count must force the output low and flag an error.
        rst2 = 1'b0; cnt2 = 4'd1; di2 = 5'd9; dv2 = 1'b1;
        @(negedge clk);
        dv2 = 1'b0; start2 = 1'b1; cnt2 = 4'd2;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 3; c < 9; c++) begin
            cnt2 = 4'(c);
            @(negedge clk);
        end
        cnt2 = 4'd0;
        @(posedge clk); #1;
        cmp("n9_pwm_boundary", pwm2, 1'b1);
        cmp("n9_err_clean",    err2, 1'b0);
        @(negedge clk);
        cnt2 = 4'd9;
        @(posedge clk); #1;
        cmp("n9_pwm_oor",  pwm2,  1'b0);
        cmp("n9_err_oor",  err2,  1'b1);
        cmp("n9_busy_oor", busy2, 1'b1);
        @(negedge clk);
        cnt2 = 4'd1;
        @(posedge clk); #1;
        cmp("n9_pwm_after", pwm2, 1'b1);
        cmp("n9_err_stick", err2, 1'b1);

        @(posedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
